cacc_reg_pingpong_ctrl: RTL and testbench

//  Sequences the two CACC per-layer (D_*) register groups as a ping-pong pair.

---
 rtl/cacc_reg_pingpong_ctrl.sv | 123 ++++++++++++
 tb/tb_cacc_reg_pingpong_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cacc_reg_pingpong_ctrl.sv
// Ping-pong sequencer for the two CACC per-layer register groups: routes CSB
// writes to the producer group, owns op_en, status/pointer regs and layer retire.
module cacc_reg_pingpong_ctrl #(
  parameter logic [11:0] D_LO      = 12'h008,
  parameter logic [11:0] D_HI      = 12'h034,
  parameter logic [11:0] S_STATUS  = 12'h000,
  parameter logic [11:0] S_POINTER = 12'h004
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        csb_wr_en,
  input  logic [11:0] csb_offset,
  input  logic [31:0] csb_wr_data,
  output logic [31:0] csb_rd_data,
  output logic [1:0]  grp_wr_en,
  input  logic [31:0] grp_rd_data0,
  input  logic [31:0] grp_rd_data1,
  input  logic [1:0]  grp_op_en_trig,
  output logic [1:0]  grp_op_en,
  input  logic        dp_done,
  output logic        reg2dp_op_en,
  output logic        reg2dp_consumer,
  output logic [1:0]  intr_done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  logic       producer_q, producer_d;
  logic       consumer_q, consumer_d;
  logic [1:0] op_en_q, op_en_d;
  logic [1:0] intr_q, intr_d;
  logic       retire_q, retire_d;
  logic       dp_en_q, dp_en_d;

  logic       in_d_range;
  logic       retire;
  logic [1:0] st0, st1;
  logic       unused_wr_data;

  assign unused_wr_data = ^csb_wr_data[31:1];

  function automatic logic [1:0] grp_status(input logic en, input logic is_consumer);
    if (!en)              return ST_IDLE;
    else if (is_consumer) return ST_RUNNING;
    else                  return ST_PENDING;
  endfunction

  // State register
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      producer_q <= 1'b0;
      consumer_q <= 1'b0;
      op_en_q    <= 2'b00;
      intr_q     <= 2'b00;
      retire_q   <= 1'b0;
      dp_en_q    <= 1'b0;
    end else begin
      producer_q <= producer_d;
      consumer_q <= consumer_d;
      op_en_q    <= op_en_d;
      intr_q     <= intr_d;
      retire_q   <= retire_d;
      dp_en_q    <= dp_en_d;
    end
  end

  // Next state: pointer load, layer retire, op_en set (set wins over retire clear)
  always_comb begin
    producer_d = producer_q;
    consumer_d = consumer_q;
    op_en_d    = op_en_q;
    intr_d     = 2'b00;
    retire_d   = 1'b0;

    // retire_q masks the stale enable cycle right after a retire
    retire = dp_done & dp_en_q & ~retire_q;

    if (csb_wr_en && (csb_offset == S_POINTER)) begin
      producer_d = csb_wr_data[0];
    end

    if (retire) begin
      op_en_d[consumer_q] = 1'b0;
      consumer_d          = ~consumer_q;
      intr_d[consumer_q]  = 1'b1;
      retire_d            = 1'b1;
    end

    op_en_d = op_en_d | (grp_op_en_trig & {2{csb_wr_data[0]}});

    dp_en_d = op_en_q[consumer_q] & ~retire_q;
  end

  // Write routing and read mux
  always_comb begin
    grp_wr_en   = 2'b00;
    csb_rd_data = 32'h0;
    in_d_range  = (csb_offset >= D_LO) && (csb_offset <= D_HI);
    st0         = grp_status(op_en_q[0], consumer_q == 1'b0);
    st1         = grp_status(op_en_q[1], consumer_q == 1'b1);

    // Only D_OP_ENABLE may reach an armed group; other writes to it are dropped
    if (csb_wr_en && in_d_range && ((csb_offset == D_LO) || !op_en_q[producer_q])) begin
      grp_wr_en[producer_q] = 1'b1;
    end

    if (in_d_range) begin
      csb_rd_data = producer_q ? grp_rd_data1 : grp_rd_data0;
    end else if (csb_offset == S_STATUS) begin
      csb_rd_data = {14'b0, st1, 14'b0, st0};
    end else if (csb_offset == S_POINTER) begin
      csb_rd_data = {15'b0, consumer_q, 15'b0, producer_q};
    end
  end

  assign grp_op_en       = op_en_q;
  assign reg2dp_op_en    = dp_en_q;
  assign reg2dp_consumer = consumer_q;
  assign intr_done       = intr_q;

endmodule

// File: tb/tb_cacc_reg_pingpong_ctrl.sv
// Table-driven bench for cacc_reg_pingpong_ctrl plus an async-reset sequence.
module tb_cacc_reg_pingpong_ctrl;

  localparam logic [31:0] RD0 = 32'hA0A0_0000;
  localparam logic [31:0] RD1 = 32'hB1B1_0001;

  logic        clk;
  logic        rstn;
  logic        csb_wr_en;
  logic [11:0] csb_offset;
  logic [31:0] csb_wr_data;
  logic [31:0] csb_rd_data;
  logic [1:0]  grp_wr_en;
  logic [31:0] grp_rd_data0;
  logic [31:0] grp_rd_data1;
  logic [1:0]  grp_op_en_trig;
  logic [1:0]  grp_op_en;
  logic        dp_done;
  logic        reg2dp_op_en;
  logic        reg2dp_consumer;
  logic [1:0]  intr_done;

  int checks = 0;
  int errors = 0;

  cacc_reg_pingpong_ctrl dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .csb_wr_en      (csb_wr_en),
    .csb_offset     (csb_offset),
    .csb_wr_data    (csb_wr_data),
    .csb_rd_data    (csb_rd_data),
    .grp_wr_en      (grp_wr_en),
    .grp_rd_data0   (grp_rd_data0),
    .grp_rd_data1   (grp_rd_data1),
    .grp_op_en_trig (grp_op_en_trig),
    .grp_op_en      (grp_op_en),
    .dp_done        (dp_done),
    .reg2dp_op_en   (reg2dp_op_en),
    .reg2dp_consumer(reg2dp_consumer),
    .intr_done      (intr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] off;
    logic [31:0] wd;
    logic [1:0]  trig;
    logic        done;
    logic [1:0]  e_wen;
    logic [31:0] e_rd;
    logic [1:0]  e_gop;
    logic        e_r2d;
    logic        e_cons;
    logic [1:0]  e_intr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [11:0] off, input logic [31:0] wd,
                              input logic [1:0] trig, input logic done, input logic [1:0] e_wen,
                              input logic [31:0] e_rd, input logic [1:0] e_gop, input logic e_r2d,
                              input logic e_cons, input logic [1:0] e_intr);
    vec_t v;
    v.we = we; v.off = off; v.wd = wd; v.trig = trig; v.done = done;
    v.e_wen = e_wen; v.e_rd = e_rd; v.e_gop = e_gop; v.e_r2d = e_r2d;
    v.e_cons = e_cons; v.e_intr = e_intr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [11:0] off, input logic [31:0] wd,
                       input logic [1:0] trig, input logic done);
    csb_wr_en = we; csb_offset = off; csb_wr_data = wd;
    grp_op_en_trig = trig; dp_done = done;
  endtask

  initial begin
    grp_rd_data0 = RD0;
    grp_rd_data1 = RD1;
    drive(1'b0, 12'h000, 32'h0, 2'b00, 1'b0);
    rstn = 1'b0;

    //               we   off     wd            trig  done  wen    rd            gop   r2d  cons intr
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h0,        2'b00, 0, 0, 2'b00)); // 0 status
    vecs.push_back(mk(0, 12'h004, 32'h0,        2'b00, 0, 2'b00, 32'h0,        2'b00, 0, 0, 2'b00)); // 1 pointer
    vecs.push_back(mk(1, 12'h010, 32'h00070003, 2'b00, 0, 2'b01, RD0,          2'b00, 0, 0, 2'b00)); // 2 write grp0
    vecs.push_back(mk(1, 12'h004, 32'h1,        2'b00, 0, 2'b00, 32'h0,        2'b00, 0, 0, 2'b00)); // 3 producer=1
    vecs.push_back(mk(1, 12'h010, 32'h00070003, 2'b00, 0, 2'b10, RD1,          2'b00, 0, 0, 2'b00)); // 4 write grp1
    vecs.push_back(mk(0, 12'h010, 32'h0,        2'b00, 0, 2'b00, RD1,          2'b00, 0, 0, 2'b00)); // 5 read grp1
    vecs.push_back(mk(1, 12'h004, 32'h0,        2'b00, 0, 2'b00, 32'h1,        2'b00, 0, 0, 2'b00)); // 6 producer=0
    vecs.push_back(mk(1, 12'h008, 32'h1,        2'b01, 0, 2'b01, RD0,          2'b00, 0, 0, 2'b00)); // 7 arm grp0
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h1,        2'b01, 0, 0, 2'b00)); // 8 +1 cycle
    vecs.push_back(mk(1, 12'h014, 32'h5,        2'b00, 0, 2'b00, RD0,          2'b01, 1, 0, 2'b00)); // 9 drop write
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h1,        2'b01, 1, 0, 2'b00)); // 10
    vecs.push_back(mk(1, 12'h004, 32'h1,        2'b00, 0, 2'b00, 32'h0,        2'b01, 1, 0, 2'b00)); // 11 producer=1
    vecs.push_back(mk(1, 12'h008, 32'h1,        2'b10, 0, 2'b10, RD1,          2'b01, 1, 0, 2'b00)); // 12 arm grp1
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h00020001, 2'b11, 1, 0, 2'b00)); // 13 run+pend
    vecs.push_back(mk(0, 12'h004, 32'h0,        2'b00, 1, 2'b00, 32'h1,        2'b11, 1, 0, 2'b00)); // 14 dp_done
    vecs.push_back(mk(0, 12'h004, 32'h0,        2'b00, 0, 2'b00, 32'h00010001, 2'b10, 1, 1, 2'b01)); // 15 intr grp0
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h00010000, 2'b10, 0, 1, 2'b00)); // 16 gap
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 1, 2'b00, 32'h00010000, 2'b10, 1, 1, 2'b00)); // 17 grp1 done
    vecs.push_back(mk(0, 12'h004, 32'h0,        2'b00, 0, 2'b00, 32'h1,        2'b00, 1, 0, 2'b10)); // 18 intr grp1
    vecs.push_back(mk(0, 12'h004, 32'h0,        2'b00, 1, 2'b00, 32'h1,        2'b00, 0, 0, 2'b00)); // 19 idle done
    vecs.push_back(mk(0, 12'h004, 32'h0,        2'b00, 0, 2'b00, 32'h1,        2'b00, 0, 0, 2'b00)); // 20 ignored
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h0,        2'b00, 0, 0, 2'b00)); // 21
    vecs.push_back(mk(1, 12'h004, 32'h0,        2'b00, 0, 2'b00, 32'h1,        2'b00, 0, 0, 2'b00)); // 22 producer=0
    vecs.push_back(mk(1, 12'h008, 32'h1,        2'b01, 0, 2'b01, RD0,          2'b00, 0, 0, 2'b00)); // 23 arm grp0
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h1,        2'b01, 0, 0, 2'b00)); // 24
    vecs.push_back(mk(1, 12'h008, 32'h1,        2'b01, 1, 2'b01, RD0,          2'b01, 1, 0, 2'b00)); // 25 set+retire
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h2,        2'b01, 1, 1, 2'b01)); // 26 grp0 pend
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h2,        2'b01, 0, 1, 2'b00)); // 27
    vecs.push_back(mk(1, 12'h008, 32'h0,        2'b10, 0, 2'b01, RD0,          2'b01, 0, 1, 2'b00)); // 28 trig data 0
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h2,        2'b01, 0, 1, 2'b00)); // 29 no set
    vecs.push_back(mk(1, 12'h040, 32'h1,        2'b00, 0, 2'b00, 32'h0,        2'b01, 0, 1, 2'b00)); // 30 outside
    vecs.push_back(mk(0, 12'h000, 32'h0,        2'b00, 0, 2'b00, 32'h2,        2'b01, 0, 1, 2'b00)); // 31

    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].off, vecs[i].wd, vecs[i].trig, vecs[i].done);
      #2;
      chk($sformatf("v%0d grp_wr_en", i),    32'(grp_wr_en),       32'(vecs[i].e_wen));
      chk($sformatf("v%0d csb_rd_data", i),  csb_rd_data,          vecs[i].e_rd);
      chk($sformatf("v%0d grp_op_en", i),    32'(grp_op_en),       32'(vecs[i].e_gop));
      chk($sformatf("v%0d reg2dp_op_en", i), 32'(reg2dp_op_en),    32'(vecs[i].e_r2d));
      chk($sformatf("v%0d consumer", i),     32'(reg2dp_consumer), 32'(vecs[i].e_cons));
      chk($sformatf("v%0d intr_done", i),    32'(intr_done),       32'(vecs[i].e_intr));
    end

    // Mid-layer async reset: arm grp1 so it runs, then pull reset between edges
    @(negedge clk);
    drive(1'b1, 12'h004, 32'h1, 2'b00, 1'b0);
    @(negedge clk);
    drive(1'b1, 12'h008, 32'h1, 2'b10, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b0, 12'h000, 32'h0, 2'b00, 1'b0);
    #1;
    chk("pre-reset reg2dp_op_en", 32'(reg2dp_op_en), 32'h1);
    chk("pre-reset grp_op_en",    32'(grp_op_en),    32'h3);
    #1 rstn = 1'b0;
    #1;
    chk("rst grp_op_en",       32'(grp_op_en),       32'h0);
    chk("rst reg2dp_op_en",    32'(reg2dp_op_en),    32'h0);
    chk("rst consumer",        32'(reg2dp_consumer), 32'h0);
    chk("rst intr_done",       32'(intr_done),       32'h0);
    chk("rst status read",     csb_rd_data,          32'h0);
    chk("rst grp_wr_en",       32'(grp_wr_en),       32'h0);
    @(negedge clk);
    rstn = 1'b1;
    csb_offset = 12'h004;
    #2;
    chk("post-reset pointer",  csb_rd_data,          32'h0);
    @(negedge clk);
    #2;
    chk("post-reset reg2dp_op_en", 32'(reg2dp_op_en), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
